// File: rtl/ariane_pkg.sv
// Shared types for the store commit queue and its dcache port.
// Holds the store entry layout, dcache request/response bundles and FSM states.
package ariane_pkg;

  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH   = 56 - DCACHE_INDEX_WIDTH;

  typedef struct packed {
    logic [55:0] paddr;
    logic [63:0] data;
    logic [7:0]  be;
    logic [1:0]  size;
  } store_entry_t;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [63:0]                   data_wdata;
    logic                          data_req;
    logic                          data_we;
    logic [7:0]                    data_be;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;

  typedef enum logic {
    IDLE,
    SEND_TAG
  } st_state_e;

  // Loads and stores alias when they share the same 8-byte word in the page.
  function automatic logic off_match(
    input logic [8:0]  word_off,
    input logic [11:0] page_off
  );
    return word_off == page_off[11:3];
  endfunction

endpackage

// File: rtl/store_commit_queue_cache_if.sv
// Index-then-tag dcache request sequencer for committed stores.
// Ports: entry/valid from the queue head, pop strobe back, dcache req/rsp, in-flight alias info.
module store_cache_if
  import ariane_pkg::*;
#(
  parameter int unsigned INDEX_W = DCACHE_INDEX_WIDTH,
  parameter int unsigned TAG_W   = DCACHE_TAG_WIDTH
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          valid_i,
  input  store_entry_t  entry_i,
  output logic          pop_o,
  output logic          idle_o,
  output logic          inflight_o,
  output logic [8:0]    inflight_off_o,
  input  dcache_req_o_t req_port_i,
  output dcache_req_i_t req_port_o
);

  st_state_e        state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [8:0]       off_q, off_d;
  logic             gnt;

  logic unused_rsp;
  assign unused_rsp = ^{req_port_i.data_rvalid, req_port_i.data_rdata};

  assign gnt = req_port_i.data_gnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      tag_q   <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      off_q   <= off_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    off_d      = off_q;
    pop_o      = 1'b0;
    req_port_o = '0;

    // Index phase is driven straight from the queue head, so it stays
    // stable for as long as the grant is withheld.
    if (valid_i) begin
      req_port_o.data_req      = 1'b1;
      req_port_o.data_we       = 1'b1;
      req_port_o.address_index = entry_i.paddr[INDEX_W-1:0];
      req_port_o.data_wdata    = entry_i.data;
      req_port_o.data_be       = entry_i.be;
      req_port_o.data_size     = entry_i.size;
    end

    unique case (state_q)
      IDLE: begin
        if (valid_i && gnt) begin
          pop_o   = 1'b1;
          tag_d   = entry_i.paddr[55:INDEX_W];
          off_d   = entry_i.paddr[11:3];
          state_d = SEND_TAG;
        end
      end
      SEND_TAG: begin
        req_port_o.tag_valid   = 1'b1;
        req_port_o.address_tag = tag_q;
        if (valid_i && gnt) begin
          pop_o   = 1'b1;
          tag_d   = entry_i.paddr[55:INDEX_W];
          off_d   = entry_i.paddr[11:3];
          state_d = SEND_TAG;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign idle_o         = (state_q == IDLE);
  assign inflight_o     = (state_q == SEND_TAG);
  assign inflight_off_o = off_q;

endmodule

// File: rtl/store_commit_queue.sv
// Circular store buffer between the LSU and dcache store port.
// Ports: LSU enqueue, commit, flush, load alias check, dcache req/rsp.
module store_commit_queue
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned INDEX_W = DCACHE_INDEX_WIDTH,
  parameter int unsigned TAG_W   = DCACHE_TAG_WIDTH
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [55:0]   paddr_i,
  input  logic [63:0]   data_i,
  input  logic [7:0]    be_i,
  input  logic [1:0]    data_size_i,
  input  logic          commit_i,
  output logic          commit_ready_o,
  output logic          no_st_pending_o,
  input  logic [11:0]   page_offset_i,
  output logic          page_offset_matches_o,
  input  dcache_req_o_t req_port_i,
  output dcache_req_i_t req_port_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  store_entry_t mem [DEPTH];

  logic [PW-1:0] issue_q, commit_q, tail_q;
  logic [PW-1:0] issue_d, commit_d, tail_d;
  logic [PW-1:0] total_cnt, spec_cnt, comm_cnt;

  logic         push, commit_fire, pop;
  logic         if_idle, if_inflight;
  logic [8:0]   if_off;
  store_entry_t head;

  // Extra wrap bit makes these differences exact modulo 2*DEPTH.
  assign total_cnt = tail_q - issue_q;
  assign spec_cnt  = tail_q - commit_q;
  assign comm_cnt  = commit_q - issue_q;

  assign ready_o        = (total_cnt != PW'(DEPTH));
  assign commit_ready_o = (spec_cnt != '0);

  assign commit_fire = commit_i && commit_ready_o;
  assign push        = valid_i && ready_o && !flush_i;

  // Commit first, then flush rewinds the tail onto the new commit point.
  always_comb begin
    commit_d = commit_q + PW'(commit_fire);
    issue_d  = issue_q + PW'(pop);
    tail_d   = tail_q;
    if (flush_i) begin
      tail_d = commit_d;
    end else if (push) begin
      tail_d = tail_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue_q  <= '0;
      commit_q <= '0;
      tail_q   <= '0;
    end else begin
      issue_q  <= issue_d;
      commit_q <= commit_d;
      tail_q   <= tail_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[tail_q[AW-1:0]] <= '{
        paddr: paddr_i,
        data:  data_i,
        be:    be_i,
        size:  data_size_i
      };
    end
  end

  assign head = mem[issue_q[AW-1:0]];

  store_cache_if #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_cache_if (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .valid_i        (comm_cnt != '0),
    .entry_i        (head),
    .pop_o          (pop),
    .idle_o         (if_idle),
    .inflight_o     (if_inflight),
    .inflight_off_o (if_off),
    .req_port_i     (req_port_i),
    .req_port_o     (req_port_o)
  );

  assign no_st_pending_o = (total_cnt == '0) && if_idle;

  // Walk outward from the oldest entry; only the first total_cnt
  // slots hold live stores.
  always_comb begin
    logic [AW-1:0] idx;
    page_offset_matches_o = 1'b0;
    idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = issue_q[AW-1:0] + AW'(k);
      if ((PW'(k) < total_cnt) &&
          off_match(mem[idx].paddr[11:3], page_offset_i)) begin
        page_offset_matches_o = 1'b1;
      end
    end
    if (if_inflight && off_match(if_off, page_offset_i)) begin
      page_offset_matches_o = 1'b1;
    end
  end

  a_no_push_full : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    valid_i |-> ready_o
  );

  a_no_empty_commit : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    commit_i |-> commit_ready_o
  );

endmodule

// File: tb/tb_store_commit_queue.sv
// Self-checking bench for store_commit_queue.
// Scoreboard follows enqueue/commit/flush and checks every dcache handshake.
module tb_store_commit_queue;
  import ariane_pkg::*;

  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [55:0]   paddr_i = '0;
  logic [63:0]   data_i = '0;
  logic [7:0]    be_i = '0;
  logic [1:0]    data_size_i = '0;
  logic          commit_i = 1'b0;
  logic          commit_ready_o;
  logic          no_st_pending_o;
  logic [11:0]   page_offset_i = '0;
  logic          page_offset_matches_o;
  dcache_req_o_t rsp;
  dcache_req_i_t req;
  logic          gnt_en = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  store_entry_t spec_q[$];
  store_entry_t exp_q[$];
  logic [43:0]  tag_q[$];

  always #5 clk = ~clk;

  always_comb begin
    rsp = '0;
    rsp.data_gnt = gnt_en & req.data_req;
  end

  store_commit_queue #(.DEPTH(DEPTH)) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_ni),
    .flush_i               (flush_i),
    .valid_i               (valid_i),
    .ready_o               (ready_o),
    .paddr_i               (paddr_i),
    .data_i                (data_i),
    .be_i                  (be_i),
    .data_size_i           (data_size_i),
    .commit_i              (commit_i),
    .commit_ready_o        (commit_ready_o),
    .no_st_pending_o       (no_st_pending_o),
    .page_offset_i         (page_offset_i),
    .page_offset_matches_o (page_offset_matches_o),
    .req_port_i            (rsp),
    .req_port_o            (req)
  );

  // Scoreboard monitor: tag phase of the previous grant, then new grants.
  always @(negedge clk) begin
    store_entry_t e;
    logic [43:0]  t;
    if (rst_ni) begin
      if (req.tag_valid) begin
        vectors++;
        if (tag_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_tag: unexpected tag_valid tag=%h", req.address_tag);
        end else begin
          t = tag_q.pop_front();
          if (req.address_tag !== t) begin
            miscompares++;
            $display("FAIL sb_tag: got %h want %h", req.address_tag, t);
          end
        end
      end
      if (req.data_req && rsp.data_gnt) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_req: unexpected grant index=%h data=%h",
                   req.address_index, req.data_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({req.address_index, req.data_wdata, req.data_be,
               req.data_size, req.data_we, req.kill_req} !==
              {e.paddr[11:0], e.data, e.be, e.size, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL sb_req: got idx=%h d=%h be=%h sz=%0d we=%b want idx=%h d=%h be=%h sz=%0d",
                     req.address_index, req.data_wdata, req.data_be,
                     req.data_size, req.data_we,
                     e.paddr[11:0], e.data, e.be, e.size);
          end
          tag_q.push_back(e.paddr[55:12]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(
    input logic [55:0] pa,
    input logic [63:0] d,
    input logic [7:0]  be,
    input logic [1:0]  sz
  );
    int n = 0;
    while (!ready_o && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL enq_wait: ready_o=%b want 1", ready_o);
    end
    valid_i = 1'b1;
    paddr_i = pa;
    data_i = d;
    be_i = be;
    data_size_i = sz;
    spec_q.push_back('{paddr: pa, data: d, be: be, size: sz});
    step();
    valid_i = 1'b0;
  endtask

  task automatic commit_one();
    commit_i = 1'b1;
    exp_q.push_back(spec_q.pop_front());
    step();
    commit_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (!(no_st_pending_o && exp_q.size() == 0 && tag_q.size() == 0)
           && n < 100) begin
      step();
      n++;
    end
    vectors++;
    if (n >= 100) begin
      miscompares++;
      $display("FAIL drain: no_st_pending=%b exp=%0d tags=%0d want 1/0/0",
               no_st_pending_o, exp_q.size(), tag_q.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({ready_o, commit_ready_o, no_st_pending_o,
         page_offset_matches_o} !== 4'b1010) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 1010",
               {ready_o, commit_ready_o, no_st_pending_o, page_offset_matches_o});
    end
    vectors++;
    if (req !== '0) begin
      miscompares++;
      $display("FAIL reset_req: got %h want 0", req);
    end
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_basic();
    enq(56'h8000_1238, 64'hDEAD_BEEF, 8'hF0, 2'd3);
    @(negedge clk);
    vectors++;
    if (req.data_req !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_noreq: data_req=%b want 0", req.data_req);
    end
    commit_one();
    @(negedge clk);
    vectors++;
    if ({req.data_req, req.address_index} !== {1'b1, 12'h238}) begin
      miscompares++;
      $display("FAIL basic_idx: req=%b idx=%h want 1 238",
               req.data_req, req.address_index);
    end
    @(negedge clk);
    vectors++;
    if ({req.tag_valid, req.address_tag} !== {1'b1, 44'h80001}) begin
      miscompares++;
      $display("FAIL basic_tag: tv=%b tag=%h want 1 80001",
               req.tag_valid, req.address_tag);
    end
    @(negedge clk);
    vectors++;
    if (no_st_pending_o !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_idle: no_st_pending=%b want 1", no_st_pending_o);
    end
    step();
  endtask

  task automatic test_fill_flush();
    for (int i = 0; i < DEPTH; i++) begin
      enq(56'h100 + 56'(i * 8), 64'(i), 8'hFF, 2'd3);
    end
    vectors++;
    if ({ready_o, commit_ready_o} !== 2'b01) begin
      miscompares++;
      $display("FAIL fill_full: ready=%b cready=%b want 0 1",
               ready_o, commit_ready_o);
    end
    flush_i = 1'b1;
    spec_q.delete();
    step();
    flush_i = 1'b0;
    vectors++;
    if ({ready_o, commit_ready_o, no_st_pending_o} !== 3'b101) begin
      miscompares++;
      $display("FAIL fill_flush: ready=%b cready=%b nsp=%b want 1 0 1",
               ready_o, commit_ready_o, no_st_pending_o);
    end
  endtask

  task automatic test_flush_with_valid();
    enq(56'h8000_2000, 64'h1111, 8'h0F, 2'd2);
    enq(56'h8000_3008, 64'h2222, 8'hFF, 2'd3);
    enq(56'h8000_4010, 64'h3333, 8'h03, 2'd1);
    commit_one();
    flush_i = 1'b1;
    valid_i = 1'b1;
    paddr_i = 56'h8000_5018;
    data_i = 64'h4444;
    spec_q.delete();
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    drain();
    vectors++;
    if ({commit_ready_o, ready_o} !== 2'b01) begin
      miscompares++;
      $display("FAIL flush_valid: cready=%b ready=%b want 0 1",
               commit_ready_o, ready_o);
    end
  endtask

  task automatic test_back_to_back();
    store_entry_t first;
    gnt_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      enq(56'h9000_0000 + 56'(i * 56'h1008), {32'hCAFE_0000, 32'(i)},
          8'hFF, 2'd3);
    end
    for (int i = 0; i < DEPTH; i++) begin
      commit_one();
    end
    first = exp_q[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if ({req.data_req, req.address_index, req.data_wdata} !==
          {1'b1, first.paddr[11:0], first.data}) begin
        miscompares++;
        $display("FAIL hold_c%0d: req=%b idx=%h d=%h want 1 %h %h", c,
                 req.data_req, req.address_index, req.data_wdata,
                 first.paddr[11:0], first.data);
      end
    end
    gnt_en = 1'b1;
    for (int c = 0; c < DEPTH; c++) begin
      @(negedge clk);
      vectors++;
      if (req.tag_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_tv%0d: tag_valid=%b want 1", c, req.tag_valid);
      end
    end
    @(negedge clk);
    vectors++;
    if ({req.tag_valid, no_st_pending_o} !== 2'b01) begin
      miscompares++;
      $display("FAIL b2b_end: tv=%b nsp=%b want 0 1",
               req.tag_valid, no_st_pending_o);
    end
    step();
  endtask

  task automatic test_alias();
    enq(56'h8000_0A48, 64'h55AA, 8'hFF, 2'd3);
    page_offset_i = 12'hA4C;
    #1;
    vectors++;
    if (page_offset_matches_o !== 1'b1) begin
      miscompares++;
      $display("FAIL alias_hit: got %b want 1", page_offset_matches_o);
    end
    page_offset_i = 12'hA50;
    #1;
    vectors++;
    if (page_offset_matches_o !== 1'b0) begin
      miscompares++;
      $display("FAIL alias_miss: got %b want 0", page_offset_matches_o);
    end
    page_offset_i = 12'hA4C;
    gnt_en = 1'b0;
    commit_one();
    gnt_en = 1'b1;
    step();
    @(negedge clk);
    vectors++;
    if ({req.tag_valid, page_offset_matches_o} !== 2'b11) begin
      miscompares++;
      $display("FAIL alias_inflight: tv=%b match=%b want 1 1",
               req.tag_valid, page_offset_matches_o);
    end
    @(negedge clk);
    vectors++;
    if (page_offset_matches_o !== 1'b0) begin
      miscompares++;
      $display("FAIL alias_gone: got %b want 0", page_offset_matches_o);
    end
    step();
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 10; r++) begin
      enq({24'h80_0000, 32'($urandom)}, {32'($urandom), 32'($urandom)},
          8'($urandom), 2'($urandom));
      commit_one();
    end
    drain();
    vectors++;
    if ({no_st_pending_o, ready_o, commit_ready_o} !== 3'b110) begin
      miscompares++;
      $display("FAIL wrap_end: nsp=%b ready=%b cready=%b want 1 1 0",
               no_st_pending_o, ready_o, commit_ready_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_flush();
    test_flush_with_valid();
    test_back_to_back();
    test_alias();
    test_wrap();
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
